// File: rtl/conv_result_writeback_pkg.sv
// conv_result_writeback_pkg
//   Shared definitions for the convolution result write-back path:
//     - wb_state_e        : write-back FSM states (IDLE/RUN/DRAIN/DONE)
//     - pixels_per_word() : derives PPW = MEM_WIDTH / PIX_WIDTH
//     - result_to_pixel() : converts an already shifted, sign-extended result
//                           into a pixel, either truncating or saturating
//   Configuration: the RESULT_SAT_EN macro is consumed by result_pixel_conv,
//   which selects the saturating or truncating mode of result_to_pixel().

package conv_result_writeback_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } wb_state_e;

    function automatic int pixels_per_word(input int mem_width, input int pix_width);
        return mem_width / pix_width;
    endfunction

    // The result is carried as 32-bit signed so one function serves every
    // parameterisation. The caller keeps only the low pix_width bits.
    function automatic logic [31:0] result_to_pixel(input logic signed [31:0] s,
                                                    input int                 pix_width,
                                                    input logic               saturate);
        logic [31:0] pix_max;
        pix_max = (32'd1 << pix_width) - 32'd1;
        if (saturate) begin
            if (s < 0) begin
                return '0;
            end
            if (s > $signed(pix_max)) begin
                return pix_max;
            end
            return s;
        end
        return s & pix_max;
    endfunction

endpackage

// File: rtl/conv_result_writeback_pixel_conv.sv
// result_pixel_conv
//   Combinational conversion of one signed bus result into an unsigned pixel:
//   arithmetic right shift by RES_SHIFT, then truncation (default) or
//   clamping to [0, 2^PIX_WIDTH-1] when the RESULT_SAT_EN macro is defined.
// Ports
//   res_data  in   RES_WIDTH  signed two's complement result
//   pixel     out  PIX_WIDTH  converted pixel

module result_pixel_conv
    import conv_result_writeback_pkg::*;
#(
    parameter int RES_WIDTH = 18,
    parameter int PIX_WIDTH = 8,
    parameter int RES_SHIFT = 0
) (
    input  logic [RES_WIDTH-1:0] res_data,
    output logic [PIX_WIDTH-1:0] pixel
);

`ifdef RESULT_SAT_EN
    localparam logic SATURATE = 1'b1;
`else
    localparam logic SATURATE = 1'b0;
`endif

    logic signed [31:0] res_ext;
    logic signed [31:0] res_shifted;
    logic [31:0]        pix_full;
    logic               unused_pix_hi;

    always_comb begin
        res_ext     = {{(32-RES_WIDTH){res_data[RES_WIDTH-1]}}, res_data};
        res_shifted = res_ext >>> RES_SHIFT;
        pix_full    = result_to_pixel(res_shifted, PIX_WIDTH, SATURATE);
        pixel       = pix_full[PIX_WIDTH-1:0];
    end

    // Upper bits are always zero after conversion; only the pixel is kept.
    assign unused_pix_hi = ^pix_full[31:PIX_WIDTH];

endmodule

// File: rtl/conv_result_writeback.sv
// conv_result_writeback
//   Drains convolution results off the bus, converts each to a pixel, packs
//   PPW pixels per memory word (first pixel at the LSBs) and writes the words
//   to consecutive addresses starting at base_addr. A pack register plus a
//   write holding register let the bus run at one result per cycle; the bus
//   stalls only while memory back-pressures.
//   Optional feature: define RESULT_SAT_EN for saturating pixel conversion.
// Ports
//   clk, rst       clock, synchronous active-high reset
//   start          1-cycle pulse, latches base_addr/num_results (IDLE only)
//   base_addr      first write address
//   num_results    results in the job (0 -> immediate done)
//   res_valid/res_ready/res_data   result bus handshake
//   mem_wr_valid/mem_wr_ready/mem_addr/mem_data   memory write handshake
//   busy           high while the job is in RUN or DRAIN
//   done           1-cycle pulse when the job completes

module conv_result_writeback
    import conv_result_writeback_pkg::*;
#(
    parameter int MEM_WIDTH  = 16,
    parameter int RES_WIDTH  = 18,
    parameter int PIX_WIDTH  = 8,
    parameter int RES_SHIFT  = 0,
    parameter int ADDR_WIDTH = 12,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]  num_results,
    input  logic                  res_valid,
    input  logic [RES_WIDTH-1:0]  res_data,
    output logic                  res_ready,
    output logic                  mem_wr_valid,
    input  logic                  mem_wr_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [MEM_WIDTH-1:0]  mem_data,
    output logic                  busy,
    output logic                  done
);

    localparam int PPW   = pixels_per_word(MEM_WIDTH, PIX_WIDTH);
    localparam int IDX_W = (PPW > 1) ? $clog2(PPW) : 1;
    localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(PPW - 1);

    wb_state_e             state_q, state_d;
    logic [CNT_WIDTH-1:0]  remain_q, remain_d;
    logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
    logic [MEM_WIDTH-1:0]  pack_q, pack_d;
    logic [IDX_W-1:0]      slot_q, slot_d;
    logic                  hold_valid_q, hold_valid_d;
    logic [ADDR_WIDTH-1:0] hold_addr_q, hold_addr_d;
    logic [MEM_WIDTH-1:0]  hold_data_q, hold_data_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [PIX_WIDTH-1:0]  pixel;
    logic [MEM_WIDTH-1:0]  pack_next;
    logic                  last_result;
    logic                  word_completes;
    logic                  hold_fire;
    logic                  hold_can_load;
    logic                  accept;

    result_pixel_conv #(
        .RES_WIDTH (RES_WIDTH),
        .PIX_WIDTH (PIX_WIDTH),
        .RES_SHIFT (RES_SHIFT)
    ) u_pixel_conv (
        .res_data (res_data),
        .pixel    (pixel)
    );

    // The pack register never holds a finished word: a pixel that would
    // finish one (PPW-th pixel or final result) is only accepted when the
    // holding register can take the word in the same cycle.
    always_comb begin
        last_result    = (remain_q == CNT_WIDTH'(1));
        word_completes = (slot_q == LAST_SLOT) || last_result;
        hold_fire      = hold_valid_q && mem_wr_ready;
        hold_can_load  = !hold_valid_q || hold_fire;
        res_ready      = (state_q == ST_RUN) && (!word_completes || hold_can_load);
        accept         = res_valid && res_ready;
        pack_next      = pack_q;
        for (int k = 0; k < PPW; k++) begin
            if (slot_q == IDX_W'(k)) begin
                pack_next[k*PIX_WIDTH +: PIX_WIDTH] = pixel;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        remain_d     = remain_q;
        next_addr_d  = next_addr_q;
        pack_d       = pack_q;
        slot_d       = slot_q;
        hold_valid_d = hold_valid_q;
        hold_addr_d  = hold_addr_q;
        hold_data_d  = hold_data_q;

        if (hold_fire) begin
            hold_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    next_addr_d = base_addr;
                    remain_d    = num_results;
                    pack_d      = '0;
                    slot_d      = '0;
                    state_d     = (num_results == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    remain_d = remain_q - CNT_WIDTH'(1);
                    if (word_completes) begin
                        // Clearing the pack register zero-pads a partial final word.
                        hold_valid_d = 1'b1;
                        hold_addr_d  = next_addr_q;
                        hold_data_d  = pack_next;
                        next_addr_d  = next_addr_q + ADDR_WIDTH'(1);
                        pack_d       = '0;
                        slot_d       = '0;
                    end else begin
                        pack_d = pack_next;
                        slot_d = slot_q + IDX_W'(1);
                    end
                    if (last_result) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Leaving on the final handshake itself puts DONE one cycle after it.
                if (hold_can_load && (slot_q == '0)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            remain_q     <= '0;
            next_addr_q  <= '0;
            pack_q       <= '0;
            slot_q       <= '0;
            hold_valid_q <= 1'b0;
            hold_addr_q  <= '0;
            hold_data_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            remain_q     <= remain_d;
            next_addr_q  <= next_addr_d;
            pack_q       <= pack_d;
            slot_q       <= slot_d;
            hold_valid_q <= hold_valid_d;
            hold_addr_q  <= hold_addr_d;
            hold_data_q  <= hold_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign mem_wr_valid = hold_valid_q;
    assign mem_addr     = hold_addr_q;
    assign mem_data     = hold_data_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_conv_result_writeback.sv
// tb_conv_result_writeback
//   Self-checking bench for conv_result_writeback with default parameters
//   (16-bit words, 8-bit pixels, 12-bit addresses). Job vectors come from a
//   table; expected writes are queued when a job starts and are matched by a
//   negedge monitor as memory accepts them. Hand-written sequences cover the
//   write latency, a zero-length job and reset in the middle of a job.
//   Follows RESULT_SAT_EN for the saturation vector.

module tb_conv_result_writeback;

    localparam int PPW = 2;

    typedef struct packed {
        logic [11:0]      base;
        logic [15:0]      num;
        logic [7:0][17:0] res;
        logic [3:0][15:0] words;
        logic [7:0]       stall;
        logic [7:0]       check_cycle;
        logic [7:0]       exp_accepted;
    } vec_t;

    typedef struct packed {
        logic [11:0] addr;
        logic [15:0] data;
    } wr_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [11:0] base_addr;
    logic [15:0] num_results;
    logic        res_valid;
    logic [17:0] res_data;
    logic        res_ready;
    logic        mem_wr_valid;
    logic        mem_wr_ready;
    logic [11:0] mem_addr;
    logic [15:0] mem_data;
    logic        busy;
    logic        done;

    int   tests_run;
    int   tests_failed;
    int   done_count;
    wr_t  exp_q[$];
    vec_t vecs[7];

    logic        prev_stall;
    logic [11:0] prev_addr;
    logic [15:0] prev_data;

    conv_result_writeback dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .base_addr    (base_addr),
        .num_results  (num_results),
        .res_valid    (res_valid),
        .res_data     (res_data),
        .res_ready    (res_ready),
        .mem_wr_valid (mem_wr_valid),
        .mem_wr_ready (mem_wr_ready),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Write monitor: pops the scoreboard on every handshake and checks that a
    // stalled write keeps its address and data.
    always @(negedge clk) begin
        wr_t exp_wr;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (done) done_count++;
            if (prev_stall) begin
                checkOutput("stallValid", 32'(mem_wr_valid), 32'd1);
                checkOutput("stallAddr", 32'(mem_addr), 32'(prev_addr));
                checkOutput("stallData", 32'(mem_data), 32'(prev_data));
            end
            if (mem_wr_valid && mem_wr_ready) begin
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("[TB] FAIL unexpectedWrite: got addr 0x%0h data 0x%0h, required no write", mem_addr, mem_data);
                end else begin
                    exp_wr = exp_q.pop_front();
                    checkOutput("wrAddr", 32'(mem_addr), 32'(exp_wr.addr));
                    checkOutput("wrData", 32'(mem_data), 32'(exp_wr.data));
                end
            end
            prev_stall = mem_wr_valid && !mem_wr_ready;
            prev_addr  = mem_addr;
            prev_data  = mem_data;
        end
    end

    // Runs one table job; entered and left just after a rising edge.
    task automatic applyStimulus(input int idx);
        vec_t v;
        int   accepted;
        int   feed;
        int   t;
        int   w;
        int   done_before;
        v = vecs[idx];
        for (int k = 0; k < (int'(v.num) + PPW - 1) / PPW; k++) begin
            exp_q.push_back('{addr: v.base + 12'(k), data: v.words[k]});
        end
        done_before  = done_count;
        start        = 1'b1;
        base_addr    = v.base;
        num_results  = v.num;
        mem_wr_ready = (v.stall == 0);
        @(posedge clk); #1;
        start    = 1'b0;
        t        = 1;
        accepted = 0;
        feed     = 0;
        while (accepted < int'(v.num) && feed < 200) begin
            res_valid    = 1'b1;
            res_data     = v.res[accepted];
            mem_wr_ready = (t >= int'(v.stall));
            @(negedge clk);
            if (v.stall != 0 && feed == int'(v.check_cycle)) begin
                checkOutput($sformatf("stallAccepted%0d", idx), 32'(accepted), 32'(v.exp_accepted));
                checkOutput($sformatf("stallResReady%0d", idx), 32'(res_ready), 32'd0);
            end
            if (res_ready) accepted++;
            @(posedge clk); #1;
            feed++;
            t++;
        end
        res_valid = 1'b0;
        res_data  = '0;
        checkOutput($sformatf("allAccepted%0d", idx), 32'(accepted), 32'(v.num));
        if (v.stall == 0) checkOutput($sformatf("throughput%0d", idx), 32'(feed), 32'(v.num));
        w = 0;
        while (done_count == done_before && w < 100) begin
            mem_wr_ready = (t >= int'(v.stall));
            @(posedge clk); #1;
            w++;
            t++;
        end
        repeat (2) @(posedge clk);
        #1;
        checkOutput($sformatf("donePulses%0d", idx), 32'(done_count - done_before), 32'd1);
        checkOutput($sformatf("writesLeft%0d", idx), 32'(exp_q.size()), 32'd0);
        checkOutput($sformatf("busyAfter%0d", idx), 32'(busy), 32'd0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "ResReady"}, 32'(res_ready), 32'd0);
        checkOutput({tag, "WrValid"}, 32'(mem_wr_valid), 32'd0);
        checkOutput({tag, "Busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "Done"}, 32'(done), 32'd0);
        checkOutput({tag, "Addr"}, 32'(mem_addr), 32'd0);
        checkOutput({tag, "Data"}, 32'(mem_data), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t v;
        int   done_before;
        tests_run    = 0;
        tests_failed = 0;
        done_count   = 0;
        prev_stall   = 1'b0;
        prev_addr    = '0;
        prev_data    = '0;
        rst          = 1'b1;
        start        = 1'b0;
        base_addr    = '0;
        num_results  = '0;
        res_valid    = 1'b0;
        res_data     = '0;
        mem_wr_ready = 1'b1;

        v = '0; v.base = 12'h010; v.num = 16'd4;
        v.res[0] = 18'd1; v.res[1] = 18'd2; v.res[2] = 18'd3; v.res[3] = 18'd4;
        v.words[0] = 16'h0201; v.words[1] = 16'h0403;
        vecs[0] = v;

        v = '0; v.base = 12'h020; v.num = 16'd3;
        v.res[0] = 18'd5; v.res[1] = 18'd6; v.res[2] = 18'd7;
        v.words[0] = 16'h0605; v.words[1] = 16'h0007;
        vecs[1] = v;

        // One word waits in the holding register and one pixel in the pack
        // register, so the fourth result is refused until memory accepts.
        v = '0; v.base = 12'h200; v.num = 16'd8;
        for (int k = 0; k < 8; k++) v.res[k] = 18'(k + 1);
        v.words[0] = 16'h0201; v.words[1] = 16'h0403; v.words[2] = 16'h0605; v.words[3] = 16'h0807;
        v.stall = 8'd12; v.check_cycle = 8'd6; v.exp_accepted = 8'd3;
        vecs[2] = v;

        v = '0; v.base = 12'h030; v.num = 16'd2;
        v.res[0] = 18'h3FFFB; v.res[1] = 18'd300;
`ifdef RESULT_SAT_EN
        v.words[0] = 16'hFF00;
`else
        v.words[0] = 16'h2CFB;
`endif
        vecs[3] = v;

        v = '0; v.base = 12'hFFF; v.num = 16'd4;
        v.res[0] = 18'h11; v.res[1] = 18'h22; v.res[2] = 18'h33; v.res[3] = 18'h44;
        v.words[0] = 16'h2211; v.words[1] = 16'h4433;
        vecs[4] = v;

        v = '0; v.base = 12'h100; v.num = 16'd5;
        v.res[0] = 18'h1FF; v.res[1] = 18'h80; v.res[2] = 18'h3FF00; v.res[3] = 18'h7F; v.res[4] = 18'hAB;
        v.words[0] = 16'h80FF; v.words[1] = 16'h7F00; v.words[2] = 16'h00AB;
        vecs[5] = v;

        v = '0; v.base = 12'h7A0; v.num = 16'd1;
        v.res[0] = 18'h42;
        v.words[0] = 16'h0042;
        vecs[6] = v;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkAllZero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Write appears the cycle after the completing result; done follows the handshake by one cycle.
        exp_q.push_back('{addr: 12'h050, data: 16'h0A09});
        start = 1'b1; base_addr = 12'h050; num_results = 16'd2;
        @(posedge clk); #1;
        start = 1'b0; res_valid = 1'b1; res_data = 18'd9;
        @(negedge clk);
        checkOutput("latBusy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        res_data = 18'd10;
        @(posedge clk); #1;
        res_valid = 1'b0; res_data = '0;
        @(negedge clk);
        checkOutput("latWrValid", 32'(mem_wr_valid), 32'd1);
        checkOutput("latWrData", 32'(mem_data), 32'h0A09);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("latDone", 32'(done), 32'd1);
        checkOutput("latBusyLow", 32'(busy), 32'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) applyStimulus(i);

        // Zero-length job: a single done pulse, no busy, no writes.
        done_before = done_count;
        start = 1'b1; base_addr = 12'h300; num_results = 16'd0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        checkOutput("zeroBusy", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("zeroDone", 32'(done_count - done_before), 32'd1);

        // Reset while a write is pending abandons the job.
        mem_wr_ready = 1'b0;
        start = 1'b1; base_addr = 12'h010; num_results = 16'd4;
        @(posedge clk); #1;
        start = 1'b0; res_valid = 1'b1; res_data = 18'd1;
        @(posedge clk); #1;
        res_data = 18'd2;
        @(posedge clk); #1;
        res_valid = 1'b0; res_data = '0;
        @(negedge clk);
        checkOutput("pendingWrite", 32'(mem_wr_valid), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkAllZero("midReset");
        exp_q.delete();
        mem_wr_ready = 1'b1;
        @(posedge clk); #1;
        applyStimulus(0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
